// File: rtl/seq_exec_unit_pkg.sv
// exec_pkg: op codes, FSM states, shift directions and width defaults
// shared by seq_exec_unit and serial_shifter.
package exec_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLT  = 4'h5,
    OP_SLTU = 4'h6,
    OP_SLL  = 4'h7,
    OP_SRL  = 4'h8,
    OP_SRA  = 4'h9,
    OP_MUL  = 4'hA
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shdir_e;

  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic shdir_e op_shift_dir(input logic [3:0] op);
    shdir_e d;
    d = SH_LL;
    if (op == OP_SRL) d = SH_RL;
    else if (op == OP_SRA) d = SH_RA;
    return d;
  endfunction

endpackage

// File: rtl/seq_exec_unit_serial_shifter.sv
// serial_shifter: iterative shifter, SHIFT_STEP bits per clock.
// i_start latches data/amount/direction; o_done is high in the cycle whose
// closing edge performs the last step, with o_result holding that step's value.
module serial_shifter
  import exec_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  shdir_e                  i_dir,
  input  logic [XLEN-1:0]         i_data,
  input  logic [$clog2(XLEN)-1:0] i_amt,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [XLEN-1:0]         o_result
);

  localparam int unsigned CW     = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

  logic [XLEN-1:0] r_data;
  logic [CW-1:0]   r_rem;
  shdir_e          r_dir;
  logic            r_busy;

  logic [CW-1:0]   w_step;
  logic [XLEN-1:0] w_next;

  // Step by SHIFT_STEP until fewer bits remain, then by the remainder.
  always_comb begin
    w_step = STEP_C;
    w_next = r_data;
    if (r_rem < STEP_C) w_step = r_rem;
    case (r_dir)
      SH_LL:   w_next = r_data << w_step;
      SH_RL:   w_next = r_data >> w_step;
      SH_RA:   w_next = $unsigned($signed(r_data) >>> w_step);
      default: w_next = r_data;
    endcase
  end

  // Datapath and remaining-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_rem  <= '0;
      r_dir  <= SH_LL;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_data <= i_data;
      r_rem  <= {1'b0, i_amt};
      r_dir  <= i_dir;
      r_busy <= (i_amt != '0);
    end else if (r_busy) begin
      r_data <= w_next;
      r_rem  <= r_rem - w_step;
      if (r_rem == w_step) r_busy <= 1'b0;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_busy && (r_rem <= STEP_C);
  assign o_result = w_next;

endmodule

// File: rtl/seq_exec_unit.sv
// seq_exec_unit: multi-cycle integer execute unit (responder side of the
// operand handshake). Logic/compare ops finish in one cycle, shifts run
// through serial_shifter. Optional macro SEQ_EXEC_UNIT_MUL_EN adds a
// radix-2 shift-add MUL (op 4'hA) with a fixed XLEN-cycle latency.
module seq_exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic [3:0]      op_in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] out,
  output logic            out_valid
);

  localparam int unsigned SW = $clog2(XLEN);

  state_e          r_state;
  logic [XLEN-1:0] r_out;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_is_shift;
  logic            w_shift_start;
  logic [SW-1:0]   w_amt;
  shdir_e          w_dir;
  logic [XLEN-1:0] w_alu;
  logic            w_sh_busy;
  logic            w_sh_done;
  logic [XLEN-1:0] w_sh_result;

`ifdef SEQ_EXEC_UNIT_MUL_EN
  logic [XLEN-1:0] r_mul_acc;
  logic [XLEN-1:0] r_mul_a;
  logic [XLEN-1:0] r_mul_b;
  logic [SW-1:0]   r_mul_cnt;
  logic [XLEN-1:0] w_mul_sum;
`endif

  assign in_ready      = (r_state == IDLE);
  assign w_accept      = in_valid && in_ready;
  assign w_amt         = b_in[SW-1:0];
  assign w_is_shift    = op_is_shift(op_in);
  assign w_dir         = op_shift_dir(op_in);
  assign w_shift_start = w_accept && w_is_shift && (w_amt != '0);

  // Single-cycle results; shifts land here only for a zero amount (out = a).
  always_comb begin
    w_alu = '0;
    case (op_in)
      OP_ADD:  w_alu = a_in + b_in;
      OP_SUB:  w_alu = a_in - b_in;
      OP_AND:  w_alu = a_in & b_in;
      OP_OR:   w_alu = a_in | b_in;
      OP_XOR:  w_alu = a_in ^ b_in;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (a_in < b_in)};
      OP_SLL,
      OP_SRL,
      OP_SRA:  w_alu = a_in;
      default: w_alu = '0;
    endcase
  end

  serial_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst),
    .i_start  (w_shift_start),
    .i_dir    (w_dir),
    .i_data   (a_in),
    .i_amt    (w_amt),
    .o_busy   (w_sh_busy),
    .o_done   (w_sh_done),
    .o_result (w_sh_result)
  );

`ifdef SEQ_EXEC_UNIT_MUL_EN
  assign w_mul_sum = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);
`endif

  // Control FSM with registered result and one-cycle out_valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_out       <= '0;
      r_out_valid <= 1'b0;
`ifdef SEQ_EXEC_UNIT_MUL_EN
      r_mul_acc   <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_cnt   <= '0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_is_shift && (w_amt != '0)) begin
              r_state <= SHIFT;
`ifdef SEQ_EXEC_UNIT_MUL_EN
            end else if (op_in == OP_MUL) begin
              r_mul_acc <= '0;
              r_mul_a   <= a_in;
              r_mul_b   <= b_in;
              r_mul_cnt <= '0;
              r_state   <= MUL;
`endif
            end else begin
              r_out       <= w_alu;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        SHIFT: begin
          if (!w_sh_busy) begin
            r_state <= IDLE;
          end else if (w_sh_done) begin
            r_out       <= w_sh_result;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        MUL: begin
`ifdef SEQ_EXEC_UNIT_MUL_EN
          r_mul_acc <= w_mul_sum;
          r_mul_a   <= r_mul_a << 1;
          r_mul_b   <= r_mul_b >> 1;
          r_mul_cnt <= r_mul_cnt + 1'b1;
          if (r_mul_cnt == SW'(XLEN-1)) begin
            r_out       <= w_mul_sum;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
`else
          r_state <= IDLE;
`endif
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_seq_exec_unit.sv
// Bench for seq_exec_unit: two instances (SHIFT_STEP 1 and 4) share the
// operand bus; each has its own in_valid, scoreboard queue and monitor.
// Latency is counted in clock edges after the accept edge up to the edge
// that raises out_valid.
module tb_seq_exec_unit;
  import exec_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] a_in, b_in;
  logic [3:0]      op_in;
  logic            vld0, vld1, rdy0, rdy1, ov0, ov1;
  logic [XLEN-1:0] out0, out1;

  seq_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .in_valid(vld0), .in_ready(rdy0), .out(out0), .out_valid(ov0)
  );

  seq_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .in_valid(vld1), .in_ready(rdy1), .out(out1), .out_valid(ov1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int unsigned lat;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned acc0     = 0;
  int unsigned acc1     = 0;
  logic [31:0] last0    = '0;
  logic [31:0] last1    = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, want, $time);
    end
  endtask

  // Reference results straight from the operation definitions.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = {27'b0, b[4:0]};
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h6: return (a < b) ? 32'd1 : 32'd0;
      4'h7: return a << sh;
      4'h8: return a >> sh;
      4'h9: return $unsigned($signed(a) >>> sh);
`ifdef SEQ_EXEC_UNIT_MUL_EN
      4'hA: return a * b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int unsigned lat_model(input logic [3:0] op, input logic [31:0] b, input int unsigned step);
    int unsigned n;
    n = {27'b0, b[4:0]};
    if (op inside {4'h7, 4'h8, 4'h9}) return (n == 0) ? 0 : (n + step - 1) / step;
`ifdef SEQ_EXEC_UNIT_MUL_EN
    if (op == 4'hA) return 32;
`endif
    return 0;
  endfunction

  // Monitor, STEP=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) last0 = '0;
    else if (ov0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL u1_unexpected_valid actual=1 expected=0 t=%0t", $time);
      end else begin
        e = q0.pop_front();
        check("u1_out", out0, e.data);
        check("u1_latency", cyc - acc0, e.lat);
      end
      check("u1_ready_in_done", {31'b0, rdy0}, 32'd0);
      last0 = out0;
    end else check("u1_out_hold", out0, last0);
  end

  // Monitor, STEP=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) last1 = '0;
    else if (ov1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL u4_unexpected_valid actual=1 expected=0 t=%0t", $time);
      end else begin
        e = q1.pop_front();
        check("u4_out", out1, e.data);
        check("u4_latency", cyc - acc1, e.lat);
      end
      check("u4_ready_in_done", {31'b0, rdy1}, 32'd0);
      last1 = out1;
    end else check("u4_out_hold", out1, last1);
  end

  // Issue one op to both instances, holding each in_valid until its
  // out_valid; operands are scrambled once both have accepted.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want);
    bit          accd0 = 1'b0;
    bit          accd1 = 1'b0;
    int unsigned n     = 0;
    op_in = op; a_in = a; b_in = b;
    vld0 = 1'b1; vld1 = 1'b1;
    q0.push_back('{want, lat_model(op, b, 1)});
    q1.push_back('{want, lat_model(op, b, 4)});
    while (vld0 || vld1) begin
      if (accd0 && accd1) begin
        a_in = $urandom; b_in = $urandom; op_in = 4'($urandom);
      end
      if (vld0 && !accd0 && rdy0) begin acc0 = cyc + 1; accd0 = 1'b1; end
      else if (vld0 && accd0 && ov0) vld0 = 1'b0;
      if (vld1 && !accd1 && rdy1) begin acc1 = cyc + 1; accd1 = 1'b1; end
      else if (vld1 && accd1 && ov1) vld1 = 1'b0;
      if (vld0 || vld1) begin
        if (n >= 200) begin
          checks++; failures++;
          $display("FAIL op_timeout actual=no_out_valid expected=out_valid op=%h", op);
          vld0 = 1'b0; vld1 = 1'b0;
        end else begin
          @(negedge clk);
          n++;
        end
      end
    end
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
    a_in = '0; b_in = '0; op_in = '0;
    repeat (3) @(negedge clk);
    check("reset_out", out0, 32'd0);
    check("reset_out_valid", {31'b0, ov0}, 32'd0);
    check("reset_in_ready", {31'b0, rdy0}, 32'd1);
    #2 rst = 1'b1;
    @(negedge clk);

    // Directed cases, issued back to back.
    run_op(4'h0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    run_op(4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    run_op(4'h5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    run_op(4'h6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    run_op(4'h9, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF);
    run_op(4'h7, 32'h1234_5678, 32'd0,         32'h1234_5678);
    run_op(4'h7, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000);
    run_op(4'h8, 32'h8000_0000, 32'd4,         32'h0800_0000);
    run_op(4'h9, 32'h8000_0000, 32'd4,         32'hF800_0000);
    run_op(4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    run_op(4'h3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    run_op(4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
`ifdef SEQ_EXEC_UNIT_MUL_EN
    run_op(4'hA, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
`else
    run_op(4'hA, 32'h0001_0001, 32'h0001_0001, 32'h0000_0000);
`endif
    run_op(4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000);

    // Reset in the middle of an SRL by 31: op is dropped, no out_valid.
    @(negedge clk);
    check("pre_abort_ready_u1", {31'b0, rdy0}, 32'd1);
    check("pre_abort_ready_u4", {31'b0, rdy1}, 32'd1);
    op_in = 4'h8; a_in = $urandom; b_in = 32'd31;
    vld0 = 1'b1; vld1 = 1'b1;
    @(negedge clk);
    vld0 = 1'b0; vld1 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_out_u1", out0, 32'd0);
    check("abort_out_valid_u1", {31'b0, ov0}, 32'd0);
    check("abort_in_ready_u1", {31'b0, rdy0}, 32'd1);
    check("abort_out_u4", out1, 32'd0);
    check("abort_in_ready_u4", {31'b0, rdy1}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("post_reset_in_ready", {31'b0, rdy0}, 32'd1);
    repeat (40) @(negedge clk);

    // Randomized ops against the reference model.
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb));
    end

    repeat (3) @(negedge clk);
    check("u1_queue_drained", 32'(q0.size()), 32'd0);
    check("u4_queue_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
